// File: rtl/mini_src_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states,
// iteration count and the divide-by-zero quotient pattern.
package mini_src_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int ITER_COUNT = 32;
    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep or restore. Only built with MUL_DIV_UNIT_DIV_EN.
`ifdef MUL_DIV_UNIT_DIV_EN
module div_step (
    input  logic [31:0] rem_in,
    input  logic        next_bit,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic        q_bit
);

    logic [32:0] partial;
    logic [32:0] diff;

    // rem_in < divisor always holds, so partial < 2*divisor and the sign
    // of a 33-bit difference is an exact "fits" indicator.
    always_comb begin
        partial = {rem_in, next_bit};
        diff    = partial - {1'b0, divisor};
        q_bit   = ~diff[32];
        rem_out = q_bit ? diff[31:0] : partial[31:0];
    end

endmodule
`endif

// File: rtl/mul_div_unit.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and divide (restoring).
// Division hardware is present only when MUL_DIV_UNIT_DIV_EN is defined.
module mul_div_unit
    import mini_src_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] zhi,
    output logic [31:0] zlo,
    output logic        err
);

    localparam logic [5:0] LAST_ITER = 6'(ITER_COUNT - 1);

    state_t      state;
    logic [5:0]  iter_cnt;
    logic [32:0] acc_hi;
    logic [31:0] acc_lo;
    logic        q_m1;
    logic [31:0] m;
    logic        err_pend;
    logic [32:0] booth_sum;

    // acc_hi carries one guard bit so A +/- M cannot overflow for -2^31 operands.
    always_comb begin
        booth_sum = acc_hi;
        case ({acc_lo[0], q_m1})
            2'b01:   booth_sum = acc_hi + {m[31], m};
            2'b10:   booth_sum = acc_hi - {m[31], m};
            default: booth_sum = acc_hi;
        endcase
    end

`ifdef MUL_DIV_UNIT_DIV_EN
    logic        div_mode;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] rem_next;
    logic        q_bit;

    div_step u_div_step (
        .rem_in   (acc_hi[31:0]),
        .next_bit (acc_lo[31]),
        .divisor  (m),
        .rem_out  (rem_next),
        .q_bit    (q_bit)
    );
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= IDLE;
            iter_cnt <= 6'd0;
            acc_hi   <= 33'd0;
            acc_lo   <= 32'd0;
            q_m1     <= 1'b0;
            m        <= 32'd0;
            err_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            zhi      <= 32'd0;
            zlo      <= 32'd0;
`ifdef MUL_DIV_UNIT_DIV_EN
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        iter_cnt <= 6'd0;
                        q_m1     <= 1'b0;
                        if (op == OP_MUL) begin
                            acc_hi   <= 33'd0;
                            acc_lo   <= a;
                            m        <= b;
                            err_pend <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
                            div_mode <= 1'b0;
`endif
                            state    <= RUN;
                        end else begin
`ifdef MUL_DIV_UNIT_DIV_EN
                            if (b == 32'd0) begin
                                acc_hi   <= {1'b0, a};
                                acc_lo   <= DIV0_QUOTIENT;
                                err_pend <= 1'b1;
                                div_mode <= 1'b0;
                                state    <= FIN;
                            end else begin
                                acc_hi   <= 33'd0;
                                acc_lo   <= mag32(a);
                                m        <= mag32(b);
                                neg_q    <= a[31] ^ b[31];
                                neg_r    <= a[31];
                                err_pend <= 1'b0;
                                div_mode <= 1'b1;
                                state    <= RUN;
                            end
`else
                            acc_hi   <= 33'd0;
                            acc_lo   <= 32'd0;
                            err_pend <= 1'b1;
                            state    <= FIN;
`endif
                        end
                    end
                end
                RUN: begin
                    iter_cnt <= iter_cnt + 6'd1;
`ifdef MUL_DIV_UNIT_DIV_EN
                    if (div_mode) begin
                        acc_hi <= {1'b0, rem_next};
                        acc_lo <= {acc_lo[30:0], q_bit};
                    end else begin
                        {acc_hi, acc_lo, q_m1} <= {booth_sum[32], booth_sum, acc_lo};
                    end
`else
                    {acc_hi, acc_lo, q_m1} <= {booth_sum[32], booth_sum, acc_lo};
`endif
                    if (iter_cnt == LAST_ITER) begin
                        iter_cnt <= 6'd0;
                        state    <= FIN;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    err   <= err_pend;
                    state <= IDLE;
`ifdef MUL_DIV_UNIT_DIV_EN
                    if (div_mode) begin
                        zlo <= neg_q ? -acc_lo : acc_lo;
                        zhi <= neg_r ? -acc_hi[31:0] : acc_hi[31:0];
                    end else begin
                        zlo <= acc_lo;
                        zhi <= acc_hi[31:0];
                    end
`else
                    zlo <= acc_lo;
                    zhi <= acc_hi[31:0];
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit; follows MUL_DIV_UNIT_DIV_EN like the RTL.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] zhi;
    logic [31:0] zlo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mul_div_unit dut (
        .clk   (clk),
        .clear (clear),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .zhi   (zhi),
        .zlo   (zlo),
        .err   (err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic o, input logic [31:0] xa, input logic [31:0] xb);
        exp_t   e;
        longint p;
`ifdef MUL_DIV_UNIT_DIV_EN
        longint q;
        longint r;
`endif
        e.err = 1'b0;
        e.lat = 33;
        if (o == 1'b0) begin
            p    = longint'($signed(xa)) * longint'($signed(xb));
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else begin
`ifdef MUL_DIV_UNIT_DIV_EN
            if (xb == 32'd0) begin
                e.hi  = xa;
                e.lo  = 32'hFFFF_FFFF;
                e.err = 1'b1;
                e.lat = 1;
            end else begin
                q    = longint'($signed(xa)) / longint'($signed(xb));
                r    = longint'($signed(xa)) % longint'($signed(xb));
                e.lo = q[31:0];
                e.hi = r[31:0];
            end
`else
            e.hi  = 32'd0;
            e.lo  = 32'd0;
            e.err = 1'b1;
            e.lat = 1;
`endif
        end
        return e;
    endfunction

    // Called at #1 after an edge with the DUT idle; returns at #1 after the accept edge.
    task automatic issue(input logic o, input logic [31:0] xa, input logic [31:0] xb);
        sb.push_back(model(o, xa, xb));
        op    = o;
        a     = xa;
        b     = xb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Cycles counted from the accept edge; -1 when the bound expires.
    task automatic wait_done(input int from, output int lat);
        lat = -1;
        for (int k = from + 1; k <= from + 100; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (err  !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
        n_cmp++; if (zhi  !== 32'd0) begin n_bad++; $display("FAIL reset_zhi: got %h expected 0", zhi); end
        n_cmp++; if (zlo  !== 32'd0) begin n_bad++; $display("FAIL reset_zlo: got %h expected 0", zlo); end
    endtask

    task automatic test_mul();
        logic [31:0] va [6] = '{32'h0000_0007, 32'h8000_0000, 32'h0000_0000,
                                32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1234_5678};
        logic [31:0] vb [6] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h0001_2345,
                                32'hFFFF_FFFF, 32'h8000_0000, 32'h9ABC_DEF0};
        exp_t e;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, va[i], vb[i]);
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mul_busy[%0d]: got %b expected 1", i, busy); end
            wait_done(0, lat);
            e = sb.pop_front();
            n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL mul_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            n_cmp++; if (zhi !== e.hi) begin n_bad++; $display("FAIL mul_zhi[%0d]: got %h expected %h", i, zhi, e.hi); end
            n_cmp++; if (zlo !== e.lo) begin n_bad++; $display("FAIL mul_zlo[%0d]: got %h expected %h", i, zlo, e.lo); end
            n_cmp++; if (err !== e.err) begin n_bad++; $display("FAIL mul_err[%0d]: got %b expected %b", i, err, e.err); end
            @(posedge clk);
            #1;
            n_cmp++; if (done !== 1'b0 || zhi !== e.hi || zlo !== e.lo)
                begin n_bad++; $display("FAIL mul_hold[%0d]: done=%b zhi=%h zlo=%h expected done=0 %h %h", i, done, zhi, zlo, e.hi, e.lo); end
        end
    endtask

`ifdef MUL_DIV_UNIT_DIV_EN
    task automatic test_div();
        logic [31:0] va [7] = '{32'hFFFF_FFF9, 32'h0000_0007, 32'h8000_0000, 32'h0000_0064,
                                32'hFFFF_FF9C, 32'h0000_0006, 32'h7FFF_FFFF};
        logic [31:0] vb [7] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0007,
                                32'hFFFF_FFF9, 32'hFFFF_FFFD, 32'h0000_0001};
        exp_t e;
        int   lat;
        for (int i = 0; i < 7; i++) begin
            issue(1'b1, va[i], vb[i]);
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL div_busy[%0d]: got %b expected 1", i, busy); end
            wait_done(0, lat);
            e = sb.pop_front();
            n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL div_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            n_cmp++; if (zhi !== e.hi) begin n_bad++; $display("FAIL div_zhi[%0d]: got %h expected %h", i, zhi, e.hi); end
            n_cmp++; if (zlo !== e.lo) begin n_bad++; $display("FAIL div_zlo[%0d]: got %h expected %h", i, zlo, e.lo); end
            n_cmp++; if (err !== e.err) begin n_bad++; $display("FAIL div_err[%0d]: got %b expected %b", i, err, e.err); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] va [2] = '{32'h0000_0064, 32'h8000_0000};
        exp_t e;
        int   lat;
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, va[i], 32'd0);
            wait_done(0, lat);
            e = sb.pop_front();
            n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL div0_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            n_cmp++; if (zhi !== e.hi) begin n_bad++; $display("FAIL div0_zhi[%0d]: got %h expected %h", i, zhi, e.hi); end
            n_cmp++; if (zlo !== e.lo) begin n_bad++; $display("FAIL div0_zlo[%0d]: got %h expected %h", i, zlo, e.lo); end
            n_cmp++; if (err !== e.err) begin n_bad++; $display("FAIL div0_err[%0d]: got %b expected %b", i, err, e.err); end
            @(posedge clk);
            #1;
            n_cmp++; if (err !== 1'b1 || busy !== 1'b0)
                begin n_bad++; $display("FAIL div0_hold[%0d]: err=%b busy=%b expected err=1 busy=0", i, err, busy); end
        end
    endtask
`else
    task automatic test_unsupported();
        logic [31:0] va [2] = '{32'h0000_0064, 32'hFFFF_FFF9};
        logic [31:0] vb [2] = '{32'h0000_0000, 32'h0000_0002};
        exp_t e;
        int   lat;
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, va[i], vb[i]);
            wait_done(0, lat);
            e = sb.pop_front();
            n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL unsup_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            n_cmp++; if (zhi !== e.hi) begin n_bad++; $display("FAIL unsup_zhi[%0d]: got %h expected %h", i, zhi, e.hi); end
            n_cmp++; if (zlo !== e.lo) begin n_bad++; $display("FAIL unsup_zlo[%0d]: got %h expected %h", i, zlo, e.lo); end
            n_cmp++; if (err !== e.err) begin n_bad++; $display("FAIL unsup_err[%0d]: got %b expected %b", i, err, e.err); end
            @(posedge clk);
            #1;
        end
    endtask
`endif

    task automatic test_clear_abort();
        exp_t e;
        int   seen;
        issue(1'b0, 32'h0001_2345, 32'h0000_6789);
        repeat (10) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        e = sb.pop_front();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_cmp++; if (zhi !== 32'd0 || zlo !== 32'd0)
            begin n_bad++; $display("FAIL abort_result: zhi=%h zlo=%h expected 0 0", zhi, zlo); end
        n_cmp++; if (done !== 1'b0 || err !== 1'b0)
            begin n_bad++; $display("FAIL abort_flags: done=%b err=%b expected 0 0", done, err); end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end
        clear = 1'b1;
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd3;
        b     = 32'd5;
        @(posedge clk);
        #1;
        clear = 1'b0;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clear_over_start: busy=%b expected 0", busy); end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int   lat;
        issue(1'b0, 32'hFFFF_F000, 32'h0000_0123);
        repeat (5) @(posedge clk);
        #1;
        op    = 1'b1;
        a     = 32'd1;
        b     = 32'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(6, lat);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL ignore_latency: got %0d expected %0d", lat, e.lat); end
        n_cmp++; if (zhi !== e.hi || zlo !== e.lo)
            begin n_bad++; $display("FAIL ignore_result: got %h_%h expected %h_%h", zhi, zlo, e.hi, e.lo); end
        n_cmp++; if (err !== e.err) begin n_bad++; $display("FAIL ignore_err: got %b expected %b", err, e.err); end
        op    = 1'b0;
        a     = 32'd3;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_in_done_busy: got %b expected 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (done !== 1'b0 || zhi !== e.hi || zlo !== e.lo)
            begin n_bad++; $display("FAIL start_in_done_hold: done=%b got %h_%h expected 0 %h_%h", done, zhi, zlo, e.hi, e.lo); end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          lat;
        logic        o;
        logic [31:0] xa;
        logic [31:0] xb;
        for (int i = 0; i < 10; i++) begin
            o  = 1'($urandom_range(0, 1));
            xa = $urandom;
            xb = $urandom;
            if (i % 3 == 1) xb = {{28{xb[31]}}, xb[3:0]};
            if (i == 4)     xb = 32'd0;
            issue(o, xa, xb);
            wait_done(0, lat);
            e = sb.pop_front();
            n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            n_cmp++; if (zhi !== e.hi || zlo !== e.lo || err !== e.err)
                begin n_bad++; $display("FAIL b2b_result[%0d]: op=%b a=%h b=%h got %h_%h err=%b expected %h_%h err=%b",
                                        i, o, xa, xb, zhi, zlo, err, e.hi, e.lo, e.err); end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
`ifdef MUL_DIV_UNIT_DIV_EN
        test_div();
        test_div_zero();
`else
        test_unsupported();
`endif
        test_mul();
        test_clear_abort();
        test_ignore_start();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
